// File: rtl/phase_timer.sv
// phase_timer: countdown timer behind the traffic-light controller's timer port.
// A one-cycle t_start loads a phase length in seconds. A prescaler divides the
// clock down to one-second ticks, and the timer counts the phase down to expiry.
// t_done is held high after expiry until the next t_start or reset.
// Optional feature macro: PHASE_TIMER_FLICKER_EN. When it is defined, t_flicker
// also blinks at 1 Hz with a 50% duty cycle during the closing FLICKER_SECS
// seconds. When it is undefined, t_flicker simply follows t_done.
module phase_timer #(
  parameter int TICKS_PER_SEC = 100,
  parameter int FLICKER_SECS  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       t_start,
  input  logic [4:0] t_length,
  output logic       t_flicker,
  output logic       t_done,
  output logic       t_busy
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICKS_PER_SEC - 1);

  // Reject configurations the prescaler and flicker decode cannot honour.
  generate
    if (TICKS_PER_SEC < 2 || (TICKS_PER_SEC % 2) != 0) begin : g_badTicks
      $error("phase_timer: TICKS_PER_SEC must be >= 2 and even");
    end
    if (FLICKER_SECS < 0 || FLICKER_SECS > 31) begin : g_badFlicker
      $error("phase_timer: FLICKER_SECS must be in 0..31");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timerState_t;

  timerState_t     r_state;
  logic [4:0]      r_remaining;
  logic [PW-1:0]   r_prescale;
  logic            r_busy;
  logic            r_done;

  timerState_t     w_nextState;
  logic [4:0]      w_nextRemaining;
  logic [PW-1:0]   w_nextPrescale;

  // Next-state logic. A start pulse overrides the countdown. A nonzero length
  // starts or restarts the run, and a zero length expires at once. While
  // running, each prescaler wrap removes one second, and the last second
  // leads to EXPIRED, so remaining never goes below 1 during a run.
  always_comb begin
    w_nextState     = r_state;
    w_nextRemaining = r_remaining;
    w_nextPrescale  = r_prescale;
    if (t_start) begin
      w_nextPrescale = '0;
      if (t_length != 5'd0) begin
        w_nextRemaining = t_length;
        w_nextState     = RUN;
      end else begin
        w_nextState     = EXPIRED;
      end
    end else begin
      case (r_state)
        RUN: begin
          if (r_prescale == PRESCALE_MAX) begin
            w_nextPrescale  = '0;
            w_nextRemaining = r_remaining - 5'd1;
            if (r_remaining == 5'd1) begin
              w_nextState = EXPIRED;
            end
          end else begin
            w_nextPrescale = r_prescale + 1'b1;
          end
        end
        EXPIRED: w_nextState = EXPIRED;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // State register. busy and done are registered from the next state, so
  // they change on the same edge as the state and t_done drops on the
  // edge that accepts a new start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_prescale  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_remaining <= w_nextRemaining;
      r_prescale  <= w_nextPrescale;
      r_busy      <= (w_nextState == RUN);
      r_done      <= (w_nextState == EXPIRED);
    end
  end

  assign t_done = r_done;
  assign t_busy = r_busy;

`ifdef PHASE_TIMER_FLICKER_EN
  localparam logic [4:0]    FLICKER_LIM = 5'(FLICKER_SECS);
  localparam logic [PW-1:0] HALF_SEC    = PW'(TICKS_PER_SEC / 2);

  assign t_flicker = r_done |
                     (r_busy && (r_remaining <= FLICKER_LIM) && (r_prescale < HALF_SEC));
`else
  assign t_flicker = r_done;
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Self-checking bench for phase_timer with TICKS_PER_SEC=4 and FLICKER_SECS=2.
// The expected waveforms are hand-computed bit patterns. Bit k of each pattern
// is the output value after the k-th edge following the stimulus edge E.
module tb_phase_timer;

  logic       clk;
  logic       reset;
  logic       t_start;
  logic [4:0] t_length;
  logic       t_flicker;
  logic       t_done;
  logic       t_busy;

  int checkCount = 0;
  int passCount  = 0;

  phase_timer #(
    .TICKS_PER_SEC(4),
    .FLICKER_SECS (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .t_start  (t_start),
    .t_length (t_length),
    .t_flicker(t_flicker),
    .t_done   (t_done),
    .t_busy   (t_busy)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point. It counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one set of inputs so that the next rising edge (E) samples them,
  // then release the start and reset inputs just after that edge.
  task automatic applyStimulus(input logic start, input logic [4:0] len, input logic rst);
    t_start  = start;
    t_length = len;
    reset    = rst;
    @(posedge clk);
    #1;
    t_start  = 1'b0;
    reset    = 1'b0;
  endtask

  // Compare all three outputs against pattern bit k. Sampling happens at
  // the falling edge, away from the active edge.
  task automatic checkCycle(input string tag, input int k, input logic [31:0] expBusy,
                            input logic [31:0] expDone, input logic [31:0] expFlkOn);
    logic expFlk;
`ifdef PHASE_TIMER_FLICKER_EN
    expFlk = expFlkOn[k];
`else
    expFlk = expDone[k];
`endif
    @(negedge clk);
    checkOutput($sformatf("%s busy k=%0d", tag, k), t_busy, expBusy[k]);
    checkOutput($sformatf("%s done k=%0d", tag, k), t_done, expDone[k]);
    checkOutput($sformatf("%s flicker k=%0d", tag, k), t_flicker, expFlk);
  endtask

  // Directed scenarios.
  initial begin
    logic [31:0] busyPat;
    logic [31:0] donePat;
    logic [31:0] flkPat;

    t_start  = 1'b0;
    t_length = 5'd0;
    reset    = 1'b1;

    // Reset, then stay idle for 10 cycles.
    applyStimulus(1'b0, 5'd0, 1'b1);
    applyStimulus(1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 10; k++) checkCycle("idle", k, 32'd0, 32'd0, 32'd0);

    // Length 3: busy over E..E+11, flicker at 4,5,8,9, and done from 12 onward.
    busyPat = 32'b00_1111_1111_1111;
    donePat = 32'b11_0000_0000_0000;
    flkPat  = 32'b11_0011_0011_0000;
    applyStimulus(1'b1, 5'd3, 1'b0);
    for (int k = 0; k < 14; k++) checkCycle("len3", k, busyPat, donePat, flkPat);

    // Restart with length 1 while done is high. done drops at E and rises at E+4.
    busyPat = 32'b00_1111;
    donePat = 32'b11_0000;
    flkPat  = 32'b11_0011;
    applyStimulus(1'b1, 5'd1, 1'b0);
    for (int k = 0; k < 6; k++) checkCycle("len1", k, busyPat, donePat, flkPat);

    // Length 5, restarted with length 2 at E+6, so done comes at E+14.
    busyPat = 32'b11_1111;
    donePat = 32'b00_0000;
    flkPat  = 32'b00_0000;
    applyStimulus(1'b1, 5'd5, 1'b0);
    for (int k = 0; k < 6; k++) checkCycle("len5", k, busyPat, donePat, flkPat);
    busyPat = 32'b00_1111_1111;
    donePat = 32'b11_0000_0000;
    flkPat  = 32'b11_0011_0011;
    applyStimulus(1'b1, 5'd2, 1'b0);
    for (int k = 0; k < 10; k++) checkCycle("restart2", k, busyPat, donePat, flkPat);

    // Length 0: expired one edge later, and busy never rises.
    busyPat = 32'b000;
    donePat = 32'b111;
    flkPat  = 32'b111;
    applyStimulus(1'b1, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) checkCycle("len0", k, busyPat, donePat, flkPat);

    // Length 4, with reset taking effect at E+6. Everything stays 0 afterwards.
    busyPat = 32'b11_1111;
    donePat = 32'b00_0000;
    flkPat  = 32'b00_0000;
    applyStimulus(1'b1, 5'd4, 1'b0);
    for (int k = 0; k < 6; k++) checkCycle("len4", k, busyPat, donePat, flkPat);
    applyStimulus(1'b0, 5'd0, 1'b1);
    for (int k = 0; k < 20; k++) checkCycle("abort", k, 32'd0, 32'd0, 32'd0);

    // Reset wins over a start in the same cycle.
    applyStimulus(1'b1, 5'd3, 1'b1);
    for (int k = 0; k < 4; k++) checkCycle("rstwins", k, 32'd0, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
# phase_timer

Countdown timer serving the traffic-light controller's timer interface. It accepts a one-cycle `t_start` pulse with a phase length in seconds and counts that length down using a clock prescaler. It drives `t_done` when the phase expires and `t_flicker` during the closing seconds, so the controller can blink green before yellow. It sits directly under the traffic-light controller, and its ports match that controller's timer port list.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100: clock cycles per timer second; must be ≥ 2 and even.
- `FLICKER_SECS`, default 5: length in seconds of the flicker window before expiry; range 0–31.

Ports:
- `clk`  in  1  clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `t_start`  in  1  one-cycle pulse that loads `t_length` and (re)starts the countdown.
- `t_length`  in  5  phase length in seconds; sampled only when `t_start` is 1.
- `t_flicker`  out  1  flicker request; also high whenever `t_done` is high.
- `t_done`  out  1  expiry level; held until the next `t_start` or reset.
- `t_busy`  out  1  countdown in progress.

## Operation
- Registers:
  - `remaining[4:0]`
  - `prescale[$clog2(TICKS_PER_SEC)-1:0]`
  - `busy`
  - `done`
- States:
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - EXPIRED: `busy`=0, `done`=1.
- Any state, `t_start`=1, `t_length`≠0: `remaining`←`t_length`, `prescale`←0, go to RUN.
- Any state, `t_start`=1, `t_length`=0: go to EXPIRED immediately.
- `t_start` has priority over the countdown, including restart in the middle of a run.
- RUN, no `t_start`:
  - `prescale` increments each cycle.
  - At `prescale`=`TICKS_PER_SEC`-1: `prescale`←0 and `remaining` decrements.
  - If `remaining` was 1 at that point, go to EXPIRED.
- EXPIRED: hold until `t_start`. IDLE is left only by `t_start`.
- `t_done` = `done` register.
- `t_busy` = `busy` register.
- `t_flicker` = `done` OR (`busy` AND `remaining` ≤ `FLICKER_SECS` AND `prescale` < `TICKS_PER_SEC`/2).
  - This is a combinational decode of registers only; it has no input-to-output path.
- Handshake with the controller:
  - The controller samples `t_done` and issues `t_start` in the same cycle.
  - `t_done` therefore falls on the clock edge that samples `t_start`, so the new state never sees a stale done.
  - Because `t_flicker` is high with `t_done`, GREEN→FLICKER→DONE completes on expiry.
- No saturation or wrap is possible: `remaining` never decrements below 1 in RUN.
- `prescale` wraps at `TICKS_PER_SEC`-1, never at its power-of-two width.

## Timing
- Reset, synchronous on `clk`: all registers 0, state IDLE.
  - Output values during and after reset: `t_done`=0, `t_busy`=0, `t_flicker`=0.
- Reset asserted during a run aborts the run. Reset wins over a simultaneous `t_start`.
- `t_start` sampled at edge E with `t_length`=N≠0:
  - `t_busy`=1 from E.
  - `t_done` rises at E + N·`TICKS_PER_SEC` cycles, and `t_busy` falls at that same edge.
- `t_length`=0: `t_done`=1 from E, which gives one-cycle latency.
- Flicker window: `t_flicker` is high for the first `TICKS_PER_SEC`/2 cycles of each of the last `FLICKER_SECS` seconds, giving a 50% duty, 1 Hz flicker.
- `FLICKER_SECS` ≥ N: flicker starts immediately at E.
- `FLICKER_SECS`=0: no flicker before expiry.

## Configuration
- Macro `PHASE_TIMER_FLICKER_EN`.
- Defined: `t_flicker` behaves as specified above.
- Undefined: `t_flicker` = `done` only.
  - There is no pre-expiry blinking.
  - The controller still exits GREEN via FLICKER→DONE on expiry.
  - The flicker decode logic is removed.

## Test plan
All scenarios use `TICKS_PER_SEC`=4, `FLICKER_SECS`=2, macro defined.

- Reset, then idle for 10 cycles -> `t_done`, `t_busy` and `t_flicker` stay 0.
- `t_start` with `t_length`=3 at edge E -> `t_busy`=1 over E..E+11, `t_flicker`=1 at E+4, E+5, E+8, E+9 and E+12 onward, `t_done`=1 from E+12 and held.
- While `t_done`=1, pulse `t_start` with `t_length`=1 at edge E -> `t_done`=0 and `t_busy`=1 at E, `t_done`=1 again at E+4.
- `t_start` with `t_length`=5, then a second `t_start` with `t_length`=2 at E+6 -> countdown restarts, `t_done`=1 at E+6+8.
- `t_start` with `t_length`=0 -> `t_done`=1 and `t_flicker`=1 one edge later, `t_busy` stays 0.
- `t_start` with `t_length`=4, reset asserted at E+5 -> all outputs 0 from E+6, no `t_done` afterwards.
- Macro undefined, `t_length`=3 -> `t_flicker` is 0 until E+12, then 1 together with `t_done`.
